instr_prefetch_mem: RTL
=======================

// Module: instr_prefetch_mem
// PURPOSE
//  Parametrised instruction store with a loadable program port, synchronous read and
//  a small prefetch queue, feeding the IF stage of the 16-bit ThinPad pipeline.
//  Fetches run ahead of the decoder and pause while data memory owns the shared port
//  (mem_conflict). A taken branch/JR redirect flushes the queue and restarts fetch.
// PARAMETERS
//  DATA_W     16       instruction width
//  ADDR_W     16       PC width; PC is a word address, not a byte address
//  DEPTH      64       memory words; index = pc mod DEPTH, power of 2
//  QDEPTH     4        prefetch queue entries, power of 2, >=2
//  RESET_PC   16'h0000 first fetch address after reset
//  NOP_WORD   16'h0800 value driven on instr when the queue is empty
// PORTS
//  clk          in   1       system clock, rising edge
//  rst          in   1       asynchronous reset, active-high
//  load_en      in   1       write load_data into memory at load_addr this edge
//  load_addr    in   ADDR_W  program load word address (mod DEPTH)
//  load_data    in   DATA_W  program load data
//  mem_conflict in   1       data side owns memory; no new fetch issued this cycle
//  redirect     in   1       branch/jump taken; flush and refetch from redirect_pc
//  redirect_pc  in   ADDR_W  new fetch address
//  deq          in   1       consumer takes head entry this edge
//  instr_valid  out  1       queue non-empty; instr/instr_pc are the head entry
//  instr        out  DATA_W  head instruction, NOP_WORD when empty
//  instr_pc     out  ADDR_W  PC of head instruction, 0 when empty
//  q_count      out  log2(QDEPTH)+1  current queue occupancy
// BEHAVIOUR
//  - Reset (async): fetch_pc=RESET_PC, queue empty, in-flight read killed,
//    instr_valid=0, instr=NOP_WORD, instr_pc=0, q_count=0. Memory NOT cleared.
//  - Issue: read issued in cycle when !rst & !redirect & !load_en & !mem_conflict &
//    (q_count + inflight - deq_accepted) < QDEPTH; fetch_pc += 1 (wraps at 2^ADDR_W).
//  - Latency: issue at edge N -> data enters queue at edge N+1 -> instr_valid from N+1.
//    Steady state with deq held high and no stalls: one instruction per cycle.
//  - Queue: FIFO, outputs show head combinationally from queue storage. deq when empty
//    ignored. Enqueue and dequeue same edge: count unchanged. Never overflows (issue guard).
//  - mem_conflict does not cancel a read already in flight; it only blocks new issue.
//  - redirect (highest priority): at that edge queue emptied, in-flight read discarded
//    (its data never enqueued), fetch_pc<=redirect_pc; deq same cycle ignored.
//    First redirected instr valid two edges later if no stall.
//  - load_en: memory written at edge; blocks issue that cycle. Loading an address that
//    is already queued does not update the queued copy (software must redirect).
//  - Address wrap: memory index = pc[log2(DEPTH)-1:0]; instr_pc keeps full ADDR_W value.
//  - q_count reset 0, range 0..QDEPTH.
// TESTING
//  1. Load 0x4907,0x1003,0x4F01,0x4A01 at 0..3, release reset, deq=1 -> instr sequence
//     4907@0,1003@1,4F01@2,4A01@3 on consecutive cycles after 1-cycle start latency.
//  2. deq=0 after reset -> q_count rises to 4 and holds; no further issue; instr=0x4907.
//  3. Stream with mem_conflict high 3 cycles -> exactly 3-cycle bubble
//     (instr_valid=0 after drain), no lost or duplicated PC.
//  4. redirect to pc=0x0010 while queue full -> next edge q_count=0, instr=0x0800,
//     instr_valid=0; two edges later instr_pc=0x0010 valid.
//  5. DEPTH=64, redirect to 0x0040 -> fetched word equals memory[0], instr_pc=0x0040.
//  6. Assert rst mid-stream with an in-flight read -> outputs reset immediately;
//     after release, first instr is memory[RESET_PC].

Source files
------------

// File: rtl/instr_prefetch_mem.sv
// rtl/instr_prefetch_mem.sv - loadable instruction store with a prefetch queue for the IF stage
module instr_prefetch_mem #(
  parameter int              DATA_W   = 16,
  parameter int              ADDR_W   = 16,
  parameter int              DEPTH    = 64,
  parameter int              QDEPTH   = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
  parameter logic [DATA_W-1:0] NOP_WORD = 16'h0800
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_en,
  input  logic [ADDR_W-1:0]         load_addr,
  input  logic [DATA_W-1:0]         load_data,
  input  logic                      mem_conflict,
  input  logic                      redirect,
  input  logic [ADDR_W-1:0]         redirect_pc,
  input  logic                      deq,
  output logic                      instr_valid,
  output logic [DATA_W-1:0]         instr,
  output logic [ADDR_W-1:0]         instr_pc,
  output logic [$clog2(QDEPTH):0]   q_count
);

  localparam int MW = $clog2(DEPTH);
  localparam int QW = $clog2(QDEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] q_data [QDEPTH];
  logic [ADDR_W-1:0] q_pc [QDEPTH];

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] rd_pc;
  logic [DATA_W-1:0] rd_data;
  logic              inflight;
  logic [QW-1:0]     wptr;
  logic [QW-1:0]     rptr;
  logic [QW:0]       count;

  logic              deq_acc;
  logic              enq;
  logic              issue;
  logic [QW+1:0]     occ;
  logic              unused_addr_bits;

  assign deq_acc = deq && (count != '0) && !redirect;
  assign enq     = inflight && !redirect;

  // Occupancy once the in-flight word lands; a new read may only issue if it will fit.
  assign occ   = {1'b0, count} + (QW+2)'(inflight) - (QW+2)'(deq_acc);
  assign issue = !rst && !redirect && !load_en && !mem_conflict && (occ < (QW+2)'(QDEPTH));

  assign unused_addr_bits = ^{load_addr[ADDR_W-1:MW]};

  always_ff @(posedge clk) begin
    if (load_en)
      mem[load_addr[MW-1:0]] <= load_data;
    if (issue)
      rd_data <= mem[fetch_pc[MW-1:0]];
    if (enq) begin
      q_data[wptr] <= rd_data;
      q_pc[wptr]   <= rd_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      rd_pc    <= '0;
      inflight <= 1'b0;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
      inflight <= 1'b0;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        fetch_pc <= fetch_pc + 1'b1;
        rd_pc    <= fetch_pc;
      end
      if (enq)
        wptr <= wptr + 1'b1;
      if (deq_acc)
        rptr <= rptr + 1'b1;
      count <= count + (QW+1)'(enq) - (QW+1)'(deq_acc);
    end
  end

  assign instr_valid = (count != '0);
  assign instr       = instr_valid ? q_data[rptr] : NOP_WORD;
  assign instr_pc    = instr_valid ? q_pc[rptr] : '0;
  assign q_count     = count;

endmodule
